vec_fetch_ctrl: RTL and testbench

Command-driven sequencer that sits in front of the dot-product engine and drives it. It takes a command (source base, result base, length) and reads that many packed vector words from the two operand memories, one address pair per cycle. It streams the words into the engine with correctly aligned start pulses and collects each engine result into a result memory. When the command completes, it reports done or error.

---
 rtl/vec_fetch_pkg.sv | 17 +
 rtl/vec_fetch_delay_line.sv | 26 ++
 rtl/vec_fetch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_vec_fetch_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_fetch_pkg.sv
// Shared types and constants for the vector fetch sequencer.
package vec_fetch_pkg;

  localparam int unsigned START_DELAY          = 4;
  localparam int unsigned DEF_DATA_WIDTH       = 32;
  localparam int unsigned DEF_ADDR_WIDTH       = 5;
  localparam int unsigned DEF_RESULT_WIDTH     = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES   = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/vec_fetch_delay_line.sv
// Single-bit shift register with async reset; aligns eng_start with the
// operand words as they reach the engine's product stage.
module vec_fetch_delay_line
  import vec_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = START_DELAY
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[DEPTH-2:0], d};
    end
  end

  assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/vec_fetch_ctrl.sv
// Command-driven operand fetch / result collection sequencer for the
// dot-product engine. Optional DRAIN watchdog: VEC_FETCH_TIMEOUT_EN.
module vec_fetch_ctrl
  import vec_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned RESULT_WIDTH   = DEF_RESULT_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_src_base,
  input  logic [ADDR_WIDTH-1:0]   cmd_res_base,
  input  logic [ADDR_WIDTH:0]     cmd_len,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]   mem1_rdata,
  input  logic [DATA_WIDTH-1:0]   mem2_rdata,
  output logic [DATA_WIDTH-1:0]   eng_mem1,
  output logic [DATA_WIDTH-1:0]   eng_mem2,
  output logic                    eng_start,
  input  logic [RESULT_WIDTH-1:0] eng_result,
  input  logic                    eng_done,
  output logic                    res_we,
  output logic [ADDR_WIDTH-1:0]   res_addr,
  output logic [RESULT_WIDTH-1:0] res_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

`ifdef VEC_FETCH_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] src_base_q, res_base_q;
  logic [CW-1:0]         len_q, issued_q, received_q;
  logic [WD_W-1:0]       wd_q;
  logic                  err_q;
  logic                  abort_q;
  logic                  rd_valid_q;

  logic accept;
  logic last_issue;
  logic collect_ok;
  logic done_ok;
  logic done_bad;
  logic to_hit;

  assign accept     = cmd_valid && cmd_ready;
  assign last_issue = (issued_q + CNT_ONE) == len_q;
  assign collect_ok = (state_q != IDLE) && (received_q != len_q);
  assign done_ok    = eng_done && collect_ok;
  // After reset, stray results from an aborted command are dropped silently
  // until a new command is accepted.
  assign done_bad   = eng_done && !collect_ok && !((state_q == IDLE) && abort_q);
  assign to_hit     = TIMEOUT_EN && (state_q == DRAIN) && !eng_done && (wd_q == WD_LAST);

  assign mem_rd_addr = src_base_q + issued_q[ADDR_WIDTH-1:0];
  assign err         = err_q;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    mem_rd_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (cmd_len == '0) ? FIN : ISSUE;
      end
      ISSUE: begin
        mem_rd_en = 1'b1;
        busy      = 1'b1;
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if ((received_q == len_q) || to_hit) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      src_base_q <= '0;
      res_base_q <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
      abort_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      eng_mem1   <= '0;
      eng_mem2   <= '0;
      res_we     <= 1'b0;
      res_addr   <= '0;
      res_data   <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= mem_rd_en;

      if (rd_valid_q) begin
        eng_mem1 <= mem1_rdata;
        eng_mem2 <= mem2_rdata;
      end

      if (accept) begin
        src_base_q <= cmd_src_base;
        res_base_q <= cmd_res_base;
        len_q      <= cmd_len;
        issued_q   <= '0;
        received_q <= '0;
        err_q      <= 1'b0;
        abort_q    <= 1'b0;
      end else if (mem_rd_en) begin
        issued_q <= issued_q + CNT_ONE;
      end

      res_we <= done_ok;
      if (done_ok) begin
        res_addr   <= res_base_q + received_q[ADDR_WIDTH-1:0];
        res_data   <= eng_result;
        received_q <= received_q + CNT_ONE;
      end

      if (done_bad || to_hit) err_q <= 1'b1;

      if ((state_q == DRAIN) && !eng_done) wd_q <= wd_q + WD_ONE;
      else                                 wd_q <= '0;
    end
  end

  vec_fetch_delay_line #(
    .DEPTH(START_DELAY)
  ) u_start_dly (
    .clk(clk),
    .rst(rst),
    .d  (mem_rd_en),
    .q  (eng_start)
  );

endmodule

// File: tb/tb_vec_fetch_ctrl.sv
// Directed self-checking bench for vec_fetch_ctrl with operand memories and a
// 4-lane dot-product engine model (input reg, product reg, registered done).
module tb_vec_fetch_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RW = 16;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_src_base, cmd_res_base;
  logic [AW:0]   cmd_len;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem1_rdata, mem2_rdata, eng_mem1, eng_mem2;
  logic          eng_start;
  logic [RW-1:0] eng_result;
  logic          eng_done;
  logic          res_we;
  logic [AW-1:0] res_addr;
  logic [RW-1:0] res_data;
  logic          busy, done, err;

  int checks = 0;
  int errors = 0;

  vec_fetch_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESULT_WIDTH(RW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_base(cmd_src_base), .cmd_res_base(cmd_res_base), .cmd_len(cmd_len),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem1_rdata(mem1_rdata), .mem2_rdata(mem2_rdata),
    .eng_mem1(eng_mem1), .eng_mem2(eng_mem2), .eng_start(eng_start),
    .eng_result(eng_result), .eng_done(eng_done),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand memories: synchronous read.
  logic [DW-1:0] mem1 [32];
  logic [DW-1:0] mem2 [32];
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem1_rdata <= mem1[mem_rd_addr];
      mem2_rdata <= mem2[mem_rd_addr];
    end
  end

  // Engine model.
  logic [DW-1:0] in1, in2;
  logic [15:0]   prod [4];
  logic          eng_done_q;
  logic          kill, spur;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      in1 <= '0; in2 <= '0;
      for (int i = 0; i < 4; i++) prod[i] <= '0;
      eng_done_q <= 1'b0;
      eng_result <= '0;
    end else begin
      in1 <= eng_mem1;
      in2 <= eng_mem2;
      for (int i = 0; i < 4; i++) prod[i] <= 16'(in1[8*i +: 8]) * 16'(in2[8*i +: 8]);
      eng_done_q <= eng_start;
      eng_result <= prod[0] + prod[1] + prod[2] + prod[3];
    end
  end
  assign eng_done = (eng_done_q && !kill) || spur;

  // Per-command observation log; n is the cycle offset from the accept edge.
  int rd_addr_q[$];
  int rd_n_q[$];
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_n_q[$];
  int start_n, done_n;
  logic err_at_done, ready_seen;

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic fill_const();
    for (int a = 0; a < 32; a++) begin
      mem1[a] = 32'h01010101;
      mem2[a] = 32'h02020202;
    end
  endtask

  // mem1[a] has every byte = a, mem2 is all ones bytes, so the dot product is 4*a.
  task automatic fill_ramp();
    logic [7:0] b;
    for (int a = 0; a < 32; a++) begin
      b = 8'(a);
      mem1[a] = {b, b, b, b};
      mem2[a] = 32'h01010101;
    end
  endtask

  task automatic send_cmd(input int src, input int res, input int len);
    @(negedge clk);
    ready_seen   = cmd_ready;
    cmd_src_base = AW'(src);
    cmd_res_base = AW'(res);
    cmd_len      = (AW+1)'(len);
    cmd_valid    = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic collect(input int limit);
    rd_addr_q.delete(); rd_n_q.delete();
    wr_addr_q.delete(); wr_data_q.delete(); wr_n_q.delete();
    start_n = -1; done_n = -1; err_at_done = 1'bx;
    for (int n = 1; n <= limit; n++) begin
      if (mem_rd_en) begin rd_addr_q.push_back(int'(mem_rd_addr)); rd_n_q.push_back(n); end
      if (res_we) begin
        wr_addr_q.push_back(int'(res_addr));
        wr_data_q.push_back(int'(res_data));
        wr_n_q.push_back(n);
      end
      if (eng_start && start_n < 0) start_n = n;
      if (done) begin done_n = n; err_at_done = err; break; end
      @(negedge clk);
    end
  endtask

  task automatic run_cmd(input int src, input int res, input int len, input int limit);
    send_cmd(src, res, len);
    collect(limit);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_src_base = '0; cmd_res_base = '0; cmd_len = '0;
    kill = 1'b0; spur = 1'b0;
    fill_const();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: busy/done/err got %b want 000", {busy, done, err}); end
    checks++; if ({mem_rd_en, eng_start, res_we} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b want 000", {mem_rd_en, eng_start, res_we}); end
    checks++; if ({mem_rd_addr, res_addr, res_data} !== '0) begin errors++; $display("FAIL reset_addr_data: rd_addr=%0h res_addr=%0h res_data=%0h want 0", mem_rd_addr, res_addr, res_data); end
    checks++; if ({eng_mem1, eng_mem2} !== '0) begin errors++; $display("FAIL reset_eng_mem: got %h %h want 0", eng_mem1, eng_mem2); end
  endtask

  task automatic test_basic();
    fill_const();
    run_cmd(0, 8, 4, 40);
    checks++; if (ready_seen !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", ready_seen); end
    checks++; if (rd_n_q.size() != 4 || rd_n_q[0] != 1) begin errors++; $display("FAIL basic_reads: count %0d want 4 (first at k+1)", rd_n_q.size()); end
    checks++; if (start_n != 5) begin errors++; $display("FAIL basic_start: got k+%0d want k+5", start_n); end
    checks++; if (wr_n_q.size() != 4) begin errors++; $display("FAIL basic_wr_count: got %0d want 4", wr_n_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (wr_addr_q[i] != 8 + i || wr_data_q[i] != 8 || wr_n_q[i] != 7 + i) begin
          errors++; $display("FAIL basic_wr%0d: addr=%0d data=%0h cyc=k+%0d want addr=%0d data=8 cyc=k+%0d",
                             i, wr_addr_q[i], wr_data_q[i], wr_n_q[i], 8 + i, 7 + i);
        end
      end
    end
    checks++; if (done_n != 11 || err_at_done !== 1'b0) begin errors++; $display("FAIL basic_done: cyc=k+%0d err=%b want k+11 err=0", done_n, err_at_done); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL basic_done_pulse: done=%b ready=%b want 0 1", done, cmd_ready); end
  endtask

  task automatic test_wrap();
    int exp_rd [4] = '{30, 31, 0, 1};
    int exp_wa [4] = '{31, 0, 1, 2};
    int exp_wd [4] = '{120, 124, 0, 4};
    fill_ramp();
    run_cmd(30, 31, 4, 40);
    checks++; if (rd_addr_q.size() != 4 || wr_addr_q.size() != 4) begin
      errors++; $display("FAIL wrap_counts: reads=%0d writes=%0d want 4 4", rd_addr_q.size(), wr_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rd_addr_q[i] != exp_rd[i] || wr_addr_q[i] != exp_wa[i] || wr_data_q[i] != exp_wd[i]) begin
          errors++; $display("FAIL wrap_%0d: rd=%0d wa=%0d wd=%0d want rd=%0d wa=%0d wd=%0d",
                             i, rd_addr_q[i], wr_addr_q[i], wr_data_q[i], exp_rd[i], exp_wa[i], exp_wd[i]);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    run_cmd(3, 3, 0, 20);
    checks++; if (done_n != 1) begin errors++; $display("FAIL zero_done: got k+%0d want k+1", done_n); end
    checks++; if (rd_n_q.size() != 0 || wr_n_q.size() != 0 || start_n != -1) begin
      errors++; $display("FAIL zero_activity: reads=%0d writes=%0d start=%0d want 0 0 -1", rd_n_q.size(), wr_n_q.size(), start_n);
    end
    checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL zero_err: got %b want 0", err_at_done); end
  endtask

  task automatic test_full_len();
    int bad;
    fill_ramp();
    run_cmd(7, 20, 32, 80);
    checks++; if (rd_addr_q.size() != 32 || wr_addr_q.size() != 32) begin
      errors++; $display("FAIL full_counts: reads=%0d writes=%0d want 32 32", rd_addr_q.size(), wr_addr_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 32; i++)
        if (rd_addr_q[i] != (7 + i) % 32 || rd_n_q[i] != 1 + i) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL full_reads: %0d bad read slots want 0", bad); end
      bad = 0;
      for (int i = 0; i < 32; i++)
        if (wr_addr_q[i] != (20 + i) % 32 || wr_data_q[i] != 4 * ((7 + i) % 32)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL full_writes: %0d bad writes want 0", bad); end
    end
    checks++; if (done_n != 39) begin errors++; $display("FAIL full_done: got k+%0d want k+39", done_n); end
  endtask

  task automatic test_back_to_back();
    fill_ramp();
    run_cmd(2, 10, 3, 40);
    checks++; if (done_n != 10 || cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_first: done=k+%0d ready=%b want k+10 0", done_n, cmd_ready); end
    checks++; if (wr_data_q.size() != 3 || wr_data_q[2] != 16 || wr_addr_q[2] != 12) begin
      errors++; $display("FAIL b2b_first_wr: count=%0d want 3 with last 16@12", wr_data_q.size());
    end
    run_cmd(4, 0, 2, 40);
    checks++; if (ready_seen !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", ready_seen); end
    checks++; if (wr_data_q.size() != 2 || wr_data_q[0] != 16 || wr_data_q[1] != 20 || wr_addr_q[1] != 1 || done_n != 9) begin
      errors++; $display("FAIL b2b_second: count=%0d done=k+%0d want 2 writes 16,20 done k+9", wr_data_q.size(), done_n);
    end
  endtask

  task automatic test_reset_mid();
    int late_we;
    fill_ramp();
    send_cmd(0, 0, 8);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if ({mem_rd_en, busy, eng_start, res_we, done, err} !== 6'b0) begin
      errors++; $display("FAIL rstmid_strobes: rd/busy/start/we/done/err got %b want 0", {mem_rd_en, busy, eng_start, res_we, done, err});
    end
    checks++; if ({mem_rd_addr, eng_mem1, eng_mem2} !== '0) begin errors++; $display("FAIL rstmid_data: rd_addr=%0h eng_mem1=%h want 0", mem_rd_addr, eng_mem1); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    late_we = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_we) late_we++;
    end
    checks++; if (late_we != 0) begin errors++; $display("FAIL rstmid_no_we: got %0d writes want 0", late_we); end
    run_cmd(5, 3, 1, 30);
    checks++; if (wr_data_q.size() != 1 || wr_data_q[0] != 20 || wr_addr_q[0] != 3 || done_n != 8 || err_at_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_next_cmd: writes=%0d done=k+%0d want 1 write 20@3 done k+8 err 0", wr_data_q.size(), done_n);
    end
  endtask

  task automatic test_spurious();
    int we_seen;
    we_seen = 0;
    repeat (2) @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL spur_pre_err: got %b want 0", err); end
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    if (res_we) we_seen++;
    @(negedge clk);
    if (res_we) we_seen++;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL spur_err: got %b want 1", err); end
    checks++; if (we_seen != 0) begin errors++; $display("FAIL spur_no_we: got %0d writes want 0", we_seen); end
    run_cmd(0, 0, 0, 10);
    checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL spur_err_clear: got %b want 0", err_at_done); end
  endtask

  task automatic test_timeout();
    kill = 1'b1;
`ifdef VEC_FETCH_TIMEOUT_EN
    run_cmd(0, 0, 2, 60);
    checks++; if (done_n != 19 || err_at_done !== 1'b1) begin errors++; $display("FAIL timeout_fin: done=k+%0d err=%b want k+19 1", done_n, err_at_done); end
    checks++; if (wr_n_q.size() != 0) begin errors++; $display("FAIL timeout_no_we: got %0d want 0", wr_n_q.size()); end
    kill = 1'b0;
`else
    run_cmd(0, 0, 2, 40);
    checks++; if (done_n != -1 || busy !== 1'b1) begin errors++; $display("FAIL no_timeout_busy: done=k+%0d busy=%b want none 1", done_n, busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL no_timeout_err: got %b want 0", err); end
    kill = 1'b0;
    do_reset();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_full_len();
    test_back_to_back();
    test_reset_mid();
    test_spurious();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
